clk_ratio_meter: RTL

- Synthesizable checker for divided/multiplied clocks, such as those produced by the team's rational clock generators.
- Samples an asynchronous periodic signal sig_in in the clk domain and, over a programmable window of clk cycles, reports:
  - rising-edge count;
  - minimum and maximum edge-to-edge period, in clk cycles.
- Used in benches and on-chip self-test to confirm that a generated clock has the expected ratio and jitter pattern.

---
 rtl/clk_ratio_meter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/clk_ratio_meter.sv
// Clock ratio meter: counts synchronized rising edges of sig_in over a window of
// clk cycles and tracks the min/max edge-to-edge period in clk cycles.
module clk_ratio_meter #(
    parameter int WINDOW_BITS = 16,
    parameter int CNT_BITS    = 16,
    parameter int PER_BITS    = 12,
    parameter int SKIP_FIRST  = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   start,
    input  logic [WINDOW_BITS-1:0] window,
    input  logic                   sig_in,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_BITS-1:0]    edges,
    output logic [PER_BITS-1:0]    period_min,
    output logic [PER_BITS-1:0]    period_max,
    output logic                   overflow,
    output logic                   no_edge
);

    typedef enum logic [1:0] {IDLE, SKIP, MEASURE, DONE} state_t;

    localparam int SK_W = (SKIP_FIRST > 1) ? $clog2(SKIP_FIRST) : 1;
    localparam logic [SK_W-1:0]        SKIP_LAST = (SKIP_FIRST > 0) ? SK_W'(SKIP_FIRST - 1) : '0;
    localparam logic [WINDOW_BITS-1:0] WIN_ONE   = WINDOW_BITS'(1);
    localparam logic [CNT_BITS-1:0]    CNT_MAX   = '1;
    localparam logic [PER_BITS-1:0]    PER_MAX   = '1;
    localparam logic [PER_BITS-1:0]    PER_ONE   = PER_BITS'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;
    logic                   edge_det;

    state_t                 state_q, state_d;
    logic [WINDOW_BITS-1:0] win_lat_q, win_lat_d;
    logic [WINDOW_BITS-1:0] win_cnt_q, win_cnt_d;
    logic [WINDOW_BITS-1:0] win_eff;
    logic [SK_W-1:0]        skip_cnt_q, skip_cnt_d;
    logic [PER_BITS-1:0]    timer_q, timer_d;
    logic [CNT_BITS-1:0]    edges_q, edges_d;
    logic [PER_BITS-1:0]    pmin_q, pmin_d;
    logic [PER_BITS-1:0]    pmax_q, pmax_d;
    logic                   ovf_q, ovf_d;
    logic                   noedge_q, noedge_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_det = sync_q[SYNC_STAGES-1] & ~dly_q;
    assign win_eff  = (window == '0) ? WIN_ONE : window;

    always_comb begin
        state_d    = state_q;
        win_lat_d  = win_lat_q;
        win_cnt_d  = win_cnt_q;
        skip_cnt_d = skip_cnt_q;
        timer_d    = timer_q;
        edges_d    = edges_q;
        pmin_d     = pmin_q;
        pmax_d     = pmax_q;
        ovf_d      = ovf_q;
        noedge_d   = noedge_q;
        case (state_q)
            IDLE: begin
                if (start && en) begin
                    win_lat_d  = win_eff;
                    win_cnt_d  = win_eff;
                    skip_cnt_d = '0;
                    timer_d    = '0;
                    edges_d    = '0;
                    pmin_d     = PER_MAX;
                    pmax_d     = '0;
                    ovf_d      = 1'b0;
                    noedge_d   = 1'b0;
                    state_d    = SKIP;
                end
            end
            SKIP: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (edge_det && (SKIP_FIRST == 0 || skip_cnt_q == SKIP_LAST)) begin
                    // Reference edge wins even on the last window cycle.
                    timer_d   = PER_ONE;
                    win_cnt_d = win_lat_q;
                    state_d   = MEASURE;
                end else begin
                    if (edge_det) skip_cnt_d = skip_cnt_q + 1'b1;
                    win_cnt_d = win_cnt_q - 1'b1;
                    if (win_cnt_q == WIN_ONE) begin
                        noedge_d = 1'b1;
                        edges_d  = '0;
                        state_d  = DONE;
                    end
                end
            end
            MEASURE: begin
                if (!en) begin
                    state_d = IDLE;
                end else begin
                    win_cnt_d = win_cnt_q - 1'b1;
                    if (edge_det) begin
                        if (edges_q != CNT_MAX) edges_d = edges_q + 1'b1;
                        if (edges_d == CNT_MAX) ovf_d = 1'b1;
                        if (timer_q < pmin_q) pmin_d = timer_q;
                        if (timer_q > pmax_q) pmax_d = timer_q;
                        timer_d = PER_ONE;
                    end else begin
                        if (timer_q != PER_MAX) timer_d = timer_q + 1'b1;
                        if (timer_d == PER_MAX) ovf_d = 1'b1;
                    end
                    if (win_cnt_q == WIN_ONE) begin
                        noedge_d = (edges_d == '0);
                        state_d  = DONE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            win_lat_q  <= '0;
            win_cnt_q  <= '0;
            skip_cnt_q <= '0;
            timer_q    <= '0;
            edges_q    <= '0;
            pmin_q     <= PER_MAX;
            pmax_q     <= '0;
            ovf_q      <= 1'b0;
            noedge_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_lat_q  <= win_lat_d;
            win_cnt_q  <= win_cnt_d;
            skip_cnt_q <= skip_cnt_d;
            timer_q    <= timer_d;
            edges_q    <= edges_d;
            pmin_q     <= pmin_d;
            pmax_q     <= pmax_d;
            ovf_q      <= ovf_d;
            noedge_q   <= noedge_d;
        end
    end

    assign busy       = (state_q == SKIP) || (state_q == MEASURE);
    assign done       = (state_q == DONE);
    assign edges      = edges_q;
    assign period_min = pmin_q;
    assign period_max = pmax_q;
    assign overflow   = ovf_q;
    assign no_edge    = noedge_q;

endmodule
